btb_update_ctrl: RTL

Sequencer that owns the BTB set-memory write port and turns resolved-branch updates from the execute stage into read-modify-write cycles through the BTB write datapath. It queues updates, arbitrates the single memory port against fetch lookups (fetch wins), detects tag hits, and maintains one LRU bit per set. After reset it clears the set memory before accepting traffic.

---
 rtl/btb_pkg.sv | 40 ++++
 rtl/btb_upd_fifo.sv | 58 +++++
 rtl/btb_update_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared types and set-layout constants for the BTB update path.
package btb_pkg;

  localparam int TAG_W    = 27;
  localparam int TARGET_W = 32;
  localparam int FSM_W    = 2;
  localparam int SET_W    = 128;

  // Way 1 occupies the upper half of a set, way 2 the lower half.
  localparam int W1_VALID   = 127;
  localparam int W1_TAG_MSB = 126;
  localparam int W1_TAG_LSB = 100;
  localparam int W1_TGT_MSB = 99;
  localparam int W1_TGT_LSB = 68;
  localparam int W1_FSM_MSB = 67;
  localparam int W1_FSM_LSB = 66;

  localparam int W2_VALID   = 63;
  localparam int W2_TAG_MSB = 62;
  localparam int W2_TAG_LSB = 36;
  localparam int W2_TGT_MSB = 35;
  localparam int W2_TGT_LSB = 4;
  localparam int W2_FSM_MSB = 3;
  localparam int W2_FSM_LSB = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE
  } btb_state_e;

  typedef struct packed {
    logic [31:0]         pc;
    logic [TARGET_W-1:0] target;
    logic                mispredicted;
  } upd_req_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous queue of resolved-branch update requests.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  upd_req_t push_data,
  input  logic     pop,
  output upd_req_t head,
  output logic     full,
  output logic     empty,
  output logic     single
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  upd_req_t         entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign single  = (count == CNT_W'(1));
  assign head    = entries[rd_ptr];

  // Storage, pointers and occupancy; a full reset discards anything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: clears the set memory after reset, then turns queued
// branch updates into read-modify-write cycles, yielding the port to fetch.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | writing zero to set init_cnt, one set per cycle
//   ST_IDLE  | nothing queued
//   ST_READ  | reading the head entry's set (stalls while fetch owns port)
//   ST_WAIT  | memory returns data; captured into old_set
//   ST_WRITE | writing datapath result back, updating LRU, popping queue
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int SETS       = 8,
  parameter int INDEX_W    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [31:0]         upd_pc,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispredicted,
  input  logic                lookup_req,
  output logic                init_done,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [INDEX_W-1:0]  mem_addr,
  output logic [SET_W-1:0]    mem_wdata,
  input  logic [SET_W-1:0]    mem_rdata,
  output logic [SET_W-1:0]    wl_old_set,
  output logic [TAG_W-1:0]    wl_new_tag,
  output logic [TARGET_W-1:0] wl_new_target,
  output logic                wl_mispredicted,
  output logic                wl_update,
  output logic                wl_update_branch1,
  output logic                wl_update_branch2,
  output logic                wl_lru_write,
  input  logic [SET_W-1:0]    wl_write_set
);

  btb_state_e         state;
  logic [INDEX_W-1:0] init_cnt;
  logic [SETS-1:0]    lru;
  logic [SET_W-1:0]   old_set;

  upd_req_t           push_req;
  upd_req_t           head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_single;
  logic               push;

  logic [INDEX_W-1:0] head_idx;
  logic [1:0]         unused_pc_lsb;
  logic               hit1;
  logic               hit2;
  logic               way1_touch;
  logic               rd_go;
  logic               wr_go;

  assign push_req  = '{pc: upd_pc, target: upd_target, mispredicted: upd_mispredicted};
  assign upd_ready = init_done && !fifo_full;
  assign push      = upd_valid && upd_ready;

  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (wr_go),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .single    (fifo_single)
  );

  // PCs are word aligned; the two low bits carry no information.
  assign unused_pc_lsb = head.pc[1:0];
  assign head_idx      = head.pc[INDEX_W+1:2];

  assign rd_go = (state == ST_READ)  && !lookup_req;
  assign wr_go = (state == ST_WRITE) && !lookup_req;

  assign hit1 = old_set[W1_VALID] && (old_set[W1_TAG_MSB:W1_TAG_LSB] == wl_new_tag);
  assign hit2 = old_set[W2_VALID] && (old_set[W2_TAG_MSB:W2_TAG_LSB] == wl_new_tag);
  // A double hit is resolved in favour of way 1.
  assign way1_touch = hit1 || (!hit2 && !lru[head_idx]);

  assign wl_old_set        = old_set;
  assign wl_new_tag        = head.pc[31:5];
  assign wl_new_target     = head.target;
  assign wl_mispredicted   = head.mispredicted;
  assign wl_update         = (state == ST_WRITE);
  assign wl_update_branch1 = wl_update && hit1;
  assign wl_update_branch2 = wl_update && hit2 && !hit1;
  assign wl_lru_write      = lru[head_idx];

  assign busy = !fifo_empty || (state == ST_READ) || (state == ST_WAIT) || (state == ST_WRITE);

  // Port strobes are decoded from state so fetch can take the port in the
  // same cycle; qualifying with rst_n silences the clear writes the moment
  // reset asserts instead of at the next edge.
  assign mem_en    = rst_n && ((state == ST_INIT) || rd_go || wr_go);
  assign mem_we    = rst_n && ((state == ST_INIT) || wr_go);
  assign mem_addr  = (state == ST_INIT) ? init_cnt : ((rd_go || wr_go) ? head_idx : '0);
  assign mem_wdata = wr_go ? wl_write_set : '0;

  // Sequencer: clear sweep, then serialized read-modify-write per update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      old_set   <= '0;
      lru       <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + INDEX_W'(1);
          if (init_cnt == INDEX_W'(SETS - 1)) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_READ;
        end
        ST_READ: begin
          if (rd_go) state <= ST_WAIT;
        end
        ST_WAIT: begin
          old_set <= mem_rdata;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wr_go) begin
            lru[head_idx] <= way1_touch;
            state <= (!fifo_single || push) ? ST_READ : ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
